// File: rtl/sao_stat_bo_accum.sv
// sao_stat_bo_accum: per-CTB band-offset diff/count accumulator with clearing drain stream
module sao_stat_bo_accum #(
  parameter int diff_clip_bit = 4,
  parameter int n_bo_type = 5,
  parameter int sum_bit = 18,
  parameter int cnt_bit = 13
) (
  input  logic clk,
  input  logic arst_n,
  input  logic en,
  input  logic in_valid,
  output logic in_ready,
  input  logic signed [diff_clip_bit+2:0] s41,
  input  logic signed [diff_clip_bit+2:0] s31,
  input  logic signed [diff_clip_bit+1:0] s21,
  input  logic signed [diff_clip_bit:0] s11,
  input  logic [3:0][n_bo_type-1:0] bo_cate,
  input  logic [3:0] b_use,
  input  logic ctb_end,
  output logic out_valid,
  input  logic out_ready,
  output logic [n_bo_type-1:0] out_band,
  output logic signed [sum_bit-1:0] out_sum,
  output logic [cnt_bit-1:0] out_cnt,
  output logic drain_done
);
  localparam int lw = diff_clip_bit + 3;
  localparam int nb = 1 << n_bo_type;
  typedef enum logic [1:0] {ACC, FLUSH, DRAIN} state_t;
  state_t state, state_nxt;
  logic signed [lw-1:0] lane_s [4];
  logic [2:0] c [4];
  logic [3:0] f;
  logic v1, fl, acc, fire;
  logic signed [lw-1:0] s1 [4];
  logic [2:0] c1 [4];
  logic [n_bo_type-1:0] cat1 [4];
  logic [3:0] f1;
  logic signed [sum_bit-1:0] band_sum [nb];
  logic [cnt_bit-1:0] band_cnt [nb];
  logic signed [lw-1:0] d_sum [nb];
  logic [2:0] d_cnt [nb];
  logic [n_bo_type-1:0] band_nxt;

  function automatic logic signed [sum_bit-1:0] sat_add(input logic signed [sum_bit-1:0] a, input logic signed [lw-1:0] d);
    logic signed [sum_bit:0] t;
    t = (sum_bit+1)'(a) + (sum_bit+1)'(d);
    return (t[sum_bit] != t[sum_bit-1]) ? {t[sum_bit], {(sum_bit-1){~t[sum_bit]}}} : t[sum_bit-1:0];
  endfunction

  function automatic logic [cnt_bit-1:0] cnt_add(input logic [cnt_bit-1:0] a, input logic [2:0] d);
    logic [cnt_bit:0] t;
    t = {1'b0, a} + (cnt_bit+1)'(d);
    return t[cnt_bit] ? '1 : t[cnt_bit-1:0];
  endfunction

  assign in_ready = state == ACC;
  assign acc = in_valid && in_ready && en;
  assign fire = en && out_valid && out_ready;
  assign band_nxt = out_band + 1'b1;

  // lane sign extension, first-occurrence flags and per-lane used-pixel counts
  always_comb begin
    lane_s[0] = s41;
    lane_s[1] = s31;
    lane_s[2] = lw'(s21);
    lane_s[3] = lw'(s11);
    for (int k = 0; k < 4; k++) begin
      f[k] = 1'b1;
      c[k] = '0;
      for (int j = 0; j < 4; j++) begin
        if (j < k && bo_cate[j] == bo_cate[k]) f[k] = 1'b0;
        if (j >= k && b_use[j] && bo_cate[j] == bo_cate[k]) c[k] = c[k] + 3'd1;
      end
    end
  end

  // route each flagged stage-1 lane to its band; flagged lanes never share a band
  always_comb begin
    for (int b = 0; b < nb; b++) begin
      d_sum[b] = '0;
      d_cnt[b] = '0;
      for (int k = 0; k < 4; k++)
        if (v1 && f1[k] && c1[k] != 3'd0 && cat1[k] == n_bo_type'(b)) begin
          d_sum[b] = s1[k];
          d_cnt[b] = c1[k];
        end
    end
  end

  // next state: collect, let the pipeline settle, then stream every band out
  always_comb begin
    state_nxt = (state == ACC && ctb_end) ? FLUSH :
                (state == FLUSH && fl) ? DRAIN :
                (state == DRAIN && fire && &out_band) ? ACC : state;
  end

  // state register plus the two-cycle flush marker
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state <= ACC;
      fl <= 1'b0;
    end else if (en) begin
      state <= state_nxt;
      fl <= state == FLUSH && !fl;
    end
  end

  // stage 1: capture lane sums, counts, bands and flags of an accepted beat
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      v1 <= 1'b0;
      f1 <= '0;
      for (int k = 0; k < 4; k++) begin
        s1[k] <= '0;
        c1[k] <= '0;
        cat1[k] <= '0;
      end
    end else if (en) begin
      v1 <= acc;
      if (acc) begin
        f1 <= f;
        for (int k = 0; k < 4; k++) begin
          s1[k] <= lane_s[k];
          c1[k] <= c[k];
          cat1[k] <= bo_cate[k];
        end
      end
    end
  end

  // stage 2: saturating band accumulate, cleared when the band is drained
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int b = 0; b < nb; b++) begin
        band_sum[b] <= '0;
        band_cnt[b] <= '0;
      end
    end else if (en) begin
      for (int b = 0; b < nb; b++) begin
        band_sum[b] <= (fire && out_band == n_bo_type'(b)) ? '0 : sat_add(band_sum[b], d_sum[b]);
        band_cnt[b] <= (fire && out_band == n_bo_type'(b)) ? '0 : cnt_add(band_cnt[b], d_cnt[b]);
      end
    end
  end

  // drain output registers and completion pulse
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      out_valid <= 1'b0;
      out_band <= '0;
      out_sum <= '0;
      out_cnt <= '0;
      drain_done <= 1'b0;
    end else if (en) begin
      drain_done <= 1'b0;
      if (state == FLUSH && fl) begin
        out_valid <= 1'b1;
        out_band <= '0;
        out_sum <= band_sum[0];
        out_cnt <= band_cnt[0];
      end else if (fire && &out_band) begin
        out_valid <= 1'b0;
        out_band <= '0;
        out_sum <= '0;
        out_cnt <= '0;
        drain_done <= 1'b1;
      end else if (fire) begin
        out_band <= band_nxt;
        out_sum <= band_sum[band_nxt];
        out_cnt <= band_cnt[band_nxt];
      end
    end
  end
endmodule

// File: tb/tb_sao_stat_bo_accum.sv
// tb_sao_stat_bo_accum: directed vectors with a scoreboard checking the drain stream
module tb_sao_stat_bo_accum;
  localparam int NB = 32;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic en = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic ctb_end = 1'b0;
  logic in_ready, out_valid, drain_done;
  logic signed [6:0] s41 = '0;
  logic signed [6:0] s31 = '0;
  logic signed [5:0] s21 = '0;
  logic signed [4:0] s11 = '0;
  logic [3:0][4:0] bo_cate = '0;
  logic [3:0] b_use = '0;
  logic [4:0] out_band;
  logic signed [7:0] out_sum;
  logic [12:0] out_cnt;
  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;
  logic [25:0] q [$];
  int exp_sum [NB];
  int exp_cnt [NB];
  logic hold_pend = 1'b0;
  logic [25:0] hold_val = '0;

  sao_stat_bo_accum #(.sum_bit(8)) dut (
    .clk(clk), .arst_n(arst_n), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .s41(s41), .s31(s31), .s21(s21), .s11(s11), .bo_cate(bo_cate), .b_use(b_use),
    .ctb_end(ctb_end), .out_valid(out_valid), .out_ready(out_ready), .out_band(out_band),
    .out_sum(out_sum), .out_cnt(out_cnt), .drain_done(drain_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!arst_n) hold_pend = 1'b0;
    else begin
      if (hold_pend) chk("hold_stable", 32'({out_band, out_sum, out_cnt}), 32'(hold_val));
      if (out_valid && out_ready && en) begin
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got band %0d, expected none", out_band);
        end else chk("band_entry", 32'({out_band, out_sum, out_cnt}), 32'(q.pop_front()));
        n_acc++;
      end
      hold_pend = out_valid && !(out_ready && en);
      hold_val = {out_band, out_sum, out_cnt};
    end
  end

  task automatic beat(input int c0, c1, c2, c3, input logic [3:0] bu, input int a, b, c, d, input logic iv, ce);
    bo_cate = {5'(c3), 5'(c2), 5'(c1), 5'(c0)};
    b_use = bu;
    s41 = 7'(a);
    s31 = 7'(b);
    s21 = 6'(c);
    s11 = 5'(d);
    in_valid = iv;
    ctb_end = ce;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ctb_end = 1'b0;
  endtask

  task automatic push_exp();
    for (int b = 0; b < NB; b++) begin
      q.push_back({5'(b), 8'(exp_sum[b]), 13'(exp_cnt[b])});
      exp_sum[b] = 0;
      exp_cnt[b] = 0;
    end
  endtask

  task automatic run_drain(input bit bp, input int stop);
    bit done;
    done = 1'b0;
    n_acc = 0;
    if (bp) begin
      bo_cate = {4{5'd5}};
      b_use = 4'hF;
      s41 = 7'sd20;
    end
    for (int i = 0; i < 400 && !done; i++) begin
      @(posedge clk);
      #1;
      out_ready = bp ? i[0] : 1'b1;
      en = !(bp && i >= 5 && i < 8);
      in_valid = bp && out_valid && out_band < 5'd30;
      if (stop >= 0 && out_valid && out_band == 5'(stop)) begin
        arst_n = 1'b0;
        q.delete();
        done = 1'b1;
      end else if (drain_done) done = 1'b1;
    end
    out_ready = 1'b1;
    en = 1'b1;
    in_valid = 1'b0;
    chk("drain_reached", 32'(done), 32'd1);
    if (stop >= 0) begin
      chk("accepts_before_reset", n_acc, stop);
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_band", 32'(out_band), 32'd0);
      chk("rst_out_sum", 32'(out_sum), 32'd0);
      chk("rst_out_cnt", 32'(out_cnt), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      arst_n = 1'b1;
    end else begin
      chk("drain_done_accepts", n_acc, NB);
      chk("scoreboard_empty", q.size(), 0);
    end
  endtask

  initial begin
    for (int b = 0; b < NB; b++) begin
      exp_sum[b] = 0;
      exp_cnt[b] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_band", 32'(out_band), 32'd0);
    chk("reset_out_sum", 32'(out_sum), 32'd0);
    chk("reset_out_cnt", 32'(out_cnt), 32'd0);
    chk("reset_drain_done", 32'(drain_done), 32'd0);
    arst_n = 1'b1;
    @(posedge clk);
    #1;
    // single beat, all pixels in band 3
    beat(3, 3, 3, 3, 4'hF, 10, 5, 3, 1, 1'b1, 1'b0);
    beat(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 1'b0, 1'b1);
    exp_sum[3] = 10; exp_cnt[3] = 4;
    push_exp();
    run_drain(1'b0, -1);
    // four distinct bands, ctb_end on the data beat
    exp_sum[0] = -5; exp_cnt[0] = 1;
    exp_sum[1] = 7;  exp_cnt[1] = 1;
    exp_sum[2] = 2;  exp_cnt[2] = 1;
    exp_sum[3] = -1; exp_cnt[3] = 1;
    push_exp();
    beat(0, 1, 2, 3, 4'hF, -5, 7, 2, -1, 1'b1, 1'b1);
    run_drain(1'b0, -1);
    // partial dedup (pixel1 unused) and an all-unused beat
    beat(4, 9, 4, 9, 4'b1101, 6, 3, 9, 11, 1'b1, 1'b0);
    beat(20, 20, 20, 20, 4'h0, 5, 5, 5, 5, 1'b1, 1'b1);
    exp_sum[4] = 6; exp_cnt[4] = 2;
    exp_sum[9] = 3; exp_cnt[9] = 1;
    push_exp();
    run_drain(1'b0, -1);
    // positive and negative saturation of an 8-bit sum
    repeat (20) beat(7, 7, 7, 7, 4'hF, 16, 0, 0, 0, 1'b1, 1'b0);
    repeat (3) beat(8, 8, 8, 8, 4'hF, -64, 0, 0, 0, 1'b1, 1'b0);
    beat(0, 0, 0, 0, 4'h0, 0, 0, 0, 0, 1'b0, 1'b1);
    chk("in_ready_flush", 32'(in_ready), 32'd0);
    exp_sum[7] = 127;  exp_cnt[7] = 80;
    exp_sum[8] = -128; exp_cnt[8] = 12;
    push_exp();
    run_drain(1'b0, -1);
    // backpressure and stall during drain, then a fresh CTB from zero
    beat(1, 1, 2, 2, 4'hF, 4, 0, -3, 0, 1'b1, 1'b1);
    exp_sum[1] = 4;  exp_cnt[1] = 2;
    exp_sum[2] = -3; exp_cnt[2] = 2;
    push_exp();
    run_drain(1'b1, -1);
    beat(1, 5, 6, 7, 4'hF, 1, 2, 3, 4, 1'b1, 1'b1);
    exp_sum[1] = 1; exp_cnt[1] = 1;
    exp_sum[5] = 2; exp_cnt[5] = 1;
    exp_sum[6] = 3; exp_cnt[6] = 1;
    exp_sum[7] = 4; exp_cnt[7] = 1;
    push_exp();
    run_drain(1'b0, -1);
    // reset at band 12 of a drain, then only new data must appear
    beat(12, 13, 14, 31, 4'hF, 7, -7, 8, -8, 1'b1, 1'b1);
    exp_sum[12] = 7;  exp_cnt[12] = 1;
    exp_sum[13] = -7; exp_cnt[13] = 1;
    exp_sum[14] = 8;  exp_cnt[14] = 1;
    exp_sum[31] = -8; exp_cnt[31] = 1;
    push_exp();
    run_drain(1'b0, 12);
    beat(13, 13, 0, 0, 4'hF, 2, 0, 9, 0, 1'b1, 1'b1);
    exp_sum[13] = 2; exp_cnt[13] = 2;
    exp_sum[0] = 9;  exp_cnt[0] = 2;
    push_exp();
    run_drain(1'b0, -1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
